occupancy_grid_updater: RTL and testbench

Parametrised successor to the occupancy-grid datapath. Holds a WIDTH×HEIGHT grid of signed log-odds cells in on-chip RAM. Applies pipelined, saturating hit/miss updates at one per cycle, with same-cell forwarding. Also runs a self-timed clear sweep and serves a read-query port. Sits between the scan-to-map ray tracer (update producer) and the map-matching scorer (query consumer) in the SLAM pipeline.

---
 rtl/occupancy_grid_updater_if.sv | 39 +++
 rtl/occupancy_grid_updater.sv | 139 +++++++++++++
 tb/tb_occupancy_grid_updater.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/occupancy_grid_updater_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : occupancy_grid_updater_if
// Brief   : Clear, update and query handshake bundle for the occupancy grid.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface occupancy_grid_updater_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int WORD_SIZE   = 8
);
  logic                   clear_start;
  logic                   clear_done;
  logic                   busy;
  logic                   update_valid;
  logic                   update_ready;
  logic [WIDTH_BITS-1:0]  update_x;
  logic [HEIGHT_BITS-1:0] update_y;
  logic                   update_free;
  logic                   query_valid;
  logic                   query_ready;
  logic [WIDTH_BITS-1:0]  query_x;
  logic [HEIGHT_BITS-1:0] query_y;
  logic [WORD_SIZE-1:0]   query_data;
  logic                   query_data_valid;

  modport master (
    output clear_start, update_valid, update_x, update_y, update_free,
           query_valid, query_x, query_y,
    input  clear_done, busy, update_ready, query_ready, query_data, query_data_valid
  );

  modport slave (
    input  clear_start, update_valid, update_x, update_y, update_free,
           query_valid, query_x, query_y,
    output clear_done, busy, update_ready, query_ready, query_data, query_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/occupancy_grid_updater.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : occupancy_grid_updater
// Brief   : Log-odds occupancy grid with pipelined saturating updates and clear sweep.
// Revision: 1.0
// ----------------------------------------------------------------------------
module occupancy_grid_updater #(
  parameter int          WIDTH_BITS  = 8,
  parameter int          HEIGHT_BITS = 8,
  parameter int          WORD_SIZE   = 8,
  parameter int unsigned HIT_INC     = 4,
  parameter int unsigned MISS_DEC    = 1,
  parameter int          CELL_MAX    = 127,
  parameter int          CELL_MIN    = -128
) (
  input  logic                      clock,
  input  logic                      reset,
  occupancy_grid_updater_if.slave   bus
);
  localparam int c_addr_bits = WIDTH_BITS + HEIGHT_BITS;
  localparam int c_depth     = 1 << c_addr_bits;
  localparam int c_ext       = WORD_SIZE + 2;

  localparam logic signed [c_ext-1:0] c_cell_max = c_ext'(CELL_MAX);
  localparam logic signed [c_ext-1:0] c_cell_min = c_ext'(CELL_MIN);
  localparam logic signed [c_ext-1:0] c_hit_inc  = c_ext'(HIT_INC);
  localparam logic signed [c_ext-1:0] c_miss_dec = c_ext'(MISS_DEC);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_addr_bits-1:0]  r_sweep;
  logic                    r_s1_valid;
  logic                    r_s1_free;
  logic [c_addr_bits-1:0]  r_s1_addr;
  logic [WORD_SIZE-1:0]    r_mem [c_depth];
  logic [WORD_SIZE-1:0]    r_rdata;
  logic                    r_query_data_valid;
  logic                    r_clear_done;

  logic                    w_update_ready;
  logic                    w_query_ready;
  logic                    w_upd_acc;
  logic                    w_qry_acc;
  logic                    w_re;
  logic [c_addr_bits-1:0]  w_raddr;
  logic                    w_we;
  logic [c_addr_bits-1:0]  w_waddr;
  logic [WORD_SIZE-1:0]    w_wdata;
  logic [WORD_SIZE-1:0]    w_s1_result;

  logic signed [c_ext-1:0] w_old;
  logic signed [c_ext-1:0] w_clamped;
  logic signed [c_ext-1:0] w_sum;
  logic signed [c_ext-1:0] w_sat;

  always_comb begin
    w_state_next   = r_state;
    w_update_ready = 1'b0;
    w_query_ready  = 1'b0;
    w_we           = 1'b0;
    w_waddr        = r_s1_addr;
    w_wdata        = w_s1_result;
    case (r_state)
      IDLE: begin
        w_update_ready = !bus.clear_start;
        w_query_ready  = !bus.update_valid && !bus.clear_start;
        // An in-flight S1 still commits in the cycle the clear is accepted.
        w_we           = r_s1_valid;
        if (bus.clear_start) w_state_next = CLEAR;
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_sweep;
        w_wdata = '0;
        if (&r_sweep) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_upd_acc = bus.update_valid && w_update_ready;
  assign w_qry_acc = bus.query_valid && w_query_ready;
  assign w_re      = w_upd_acc || w_qry_acc;
  assign w_raddr   = w_upd_acc ? {bus.update_y, bus.update_x} : {bus.query_y, bus.query_x};

  always_comb begin
    w_old = {{2{r_rdata[WORD_SIZE-1]}}, r_rdata};
    if (w_old > c_cell_max)      w_clamped = c_cell_max;
    else if (w_old < c_cell_min) w_clamped = c_cell_min;
    else                         w_clamped = w_old;
    w_sum = r_s1_free ? (w_clamped - c_miss_dec) : (w_clamped + c_hit_inc);
    if (w_sum > c_cell_max)      w_sat = c_cell_max;
    else if (w_sum < c_cell_min) w_sat = c_cell_min;
    else                         w_sat = w_sum;
    w_s1_result = w_sat[WORD_SIZE-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state            <= IDLE;
      r_sweep            <= '0;
      r_s1_valid         <= 1'b0;
      r_s1_free          <= 1'b0;
      r_s1_addr          <= '0;
      r_rdata            <= '0;
      r_query_data_valid <= 1'b0;
      r_clear_done       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) r_sweep <= r_sweep + c_addr_bits'(1);
      r_s1_valid <= w_upd_acc;
      if (w_upd_acc) begin
        r_s1_addr <= w_raddr;
        r_s1_free <= bus.update_free;
      end
      // Write-through read bypass doubles as same-cell forwarding for S0.
      if (w_re) r_rdata <= (w_we && (w_waddr == w_raddr)) ? w_wdata : r_mem[w_raddr];
      r_query_data_valid <= w_qry_acc;
      r_clear_done       <= (r_state == CLEAR) && (&r_sweep);
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign bus.update_ready     = w_update_ready;
  assign bus.query_ready      = w_query_ready;
  assign bus.busy             = (r_state == CLEAR);
  assign bus.clear_done       = r_clear_done;
  assign bus.query_data       = r_rdata;
  assign bus.query_data_valid = r_query_data_valid;
endmodule
`default_nettype wire

// File: tb/tb_occupancy_grid_updater.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_occupancy_grid_updater
// Brief   : Directed self-checking bench for occupancy_grid_updater (4x4 grid).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_occupancy_grid_updater;
  localparam int c_wb = 2;
  localparam int c_hb = 2;
  localparam int c_ws = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  occupancy_grid_updater_if #(.WIDTH_BITS(c_wb), .HEIGHT_BITS(c_hb), .WORD_SIZE(c_ws)) bus ();

  occupancy_grid_updater #(
    .WIDTH_BITS(c_wb), .HEIGHT_BITS(c_hb), .WORD_SIZE(c_ws),
    .HIT_INC(4), .MISS_DEC(1), .CELL_MAX(127), .CELL_MIN(-128)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input int x, input int y, input bit free);
    bus.query_valid  = 1'b0;
    bus.update_x     = c_wb'(x);
    bus.update_y     = c_hb'(y);
    bus.update_free  = free;
    bus.update_valid = 1'b1;
    step();
  endtask

  task automatic query(input string tag, input int x, input int y, input int exp);
    bus.update_valid = 1'b0;
    bus.query_x      = c_wb'(x);
    bus.query_y      = c_hb'(y);
    bus.query_valid  = 1'b1;
    step();
    bus.query_valid  = 1'b0;
    check({tag, "_dv"}, int'(bus.query_data_valid), 1);
    check(tag, int'($signed(bus.query_data)), exp);
  endtask

  task automatic do_clear(input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int rdy_bad  = 0;
    bus.update_valid = 1'b0;
    bus.query_valid  = 1'b0;
    bus.clear_start  = 1'b1;
    #1;
    check({tag, "_rdy_at_start"}, int'(bus.update_ready) + int'(bus.query_ready), 0);
    step();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.busy && (bus.update_ready || bus.query_ready)) rdy_bad++;
      if (bus.clear_done) done_cnt++;
      step();
    end
    check({tag, "_busy_cycles"}, busy_cnt, 16);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_rdy_in_clear"}, rdy_bad, 0);
  endtask

  initial begin
    int stray_done;
    int stray_busy;
    bus.clear_start  = 1'b0;
    bus.update_valid = 1'b0;
    bus.update_x     = '0;
    bus.update_y     = '0;
    bus.update_free  = 1'b0;
    bus.query_valid  = 1'b0;
    bus.query_x      = '0;
    bus.query_y      = '0;

    repeat (3) step();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_clear_done", int'(bus.clear_done), 0);
    check("rst_qdv", int'(bus.query_data_valid), 0);
    check("rst_qdata", int'(bus.query_data), 0);
    reset = 1'b0;
    step();
    check("idle_update_ready", int'(bus.update_ready), 1);
    check("idle_query_ready", int'(bus.query_ready), 1);

    do_clear("clr1");
    for (int a = 0; a < 16; a++) query($sformatf("clr1_cell%0d", a), a % 4, a / 4, 0);

    upd(1, 2, 1'b0);
    query("hit_1_2", 1, 2, 4);
    upd(1, 2, 1'b1);
    upd(1, 2, 1'b1);
    upd(1, 2, 1'b1);
    query("miss3_1_2", 1, 2, 1);

    for (int i = 0; i < 40; i++) upd(3, 3, 1'b0);
    query("sat_max_3_3", 3, 3, 127);
    for (int i = 0; i < 300; i++) upd(3, 3, 1'b1);
    query("sat_min_3_3", 3, 3, -128);

    for (int i = 0; i < 10; i++) begin
      upd(0, 0, 1'b0);
      upd(0, 0, 1'b1);
    end
    query("alt_pairs_0_0", 0, 0, 30);

    for (int i = 0; i < 5; i++) begin
      upd(2, 1, 1'b0);
      upd(0, 3, 1'b0);
      upd(2, 1, 1'b1);
    end
    query("interleave_2_1", 2, 1, 15);
    query("interleave_0_3", 0, 3, 20);
    query("untouched_1_2", 1, 2, 1);

    upd(1, 1, 1'b0);
    do_clear("clr2");
    query("after_clr2_1_1", 1, 1, 0);
    query("after_clr2_0_0", 0, 0, 0);

    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_clear_done", int'(bus.clear_done), 0);
    step();
    reset = 1'b0;
    stray_done = 0;
    stray_busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.clear_done) stray_done++;
      if (bus.busy) stray_busy++;
      step();
    end
    check("abort_no_done", stray_done, 0);
    check("abort_no_busy", stray_busy, 0);

    do_clear("clr3");
    query("after_clr3_3_3", 3, 3, 0);
    query("after_clr3_2_1", 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
